instr_word_encoder: RTL
=======================

# instr_word_encoder

Streaming MIPS instruction encoder: the inverse of the control unit's op/funct decode. Accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready handshake and emits 32-bit instruction words with sequential word addresses for the instruction-memory write port. Pseudo-instructions BLT/BGE expand to two words. Used by the boot loader and test harness to build programs in place.

## Interface
- `ADDR_W`, default 8: width of the word address; wraps at 2^ADDR_W.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous restart: address to 0, flags cleared, pending output dropped.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_kind`  in  5  mnemonic code (`instr_kind_e`).
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register/shift fields.
- `in_imm`  in  16  immediate / branch offset, emitted unchanged.
- `in_target`  in  26  jump target field.
- `out_valid`  out  1  word valid.
- `out_ready`  in  1  memory accepts word.
- `out_instr`  out  32  encoded word.
- `out_addr`  out  ADDR_W  word address of `out_instr`.
- `err`  out  1  sticky: unsupported kind seen.
- `wrap`  out  1  sticky: address wrapped past max.

## Operation
- Kinds: ADD, SUB, AND, OR, SLT (R-type, funct 0x20/0x22/0x24/0x25/0x2A); SLL (funct 0x00, uses shamt); JR (funct 0x08, rs only); LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, ADDIU 0x09 (I-type); J 0x02, JAL 0x03 (J-type); NOP = all-zero word; BLT, BGE (pseudo).
- R-type: {0, rs, rt, rd, shamt, funct}; shamt forced 0 except SLL; JR forces rt=rd=0.
- BLT: word0 `slt $1,rs,rt`, word1 `bne $1,$0,imm`. BGE: same word0, word1 `beq $1,$0,imm`. $1 is reserved.
- Unsupported kind code: request accepted, no word emitted, `err` set.
- FSM states: IDLE (no word pending), LAST (holding final word), FIRST (holding word0 of pseudo, word1 latched).
  - IDLE, accept: single-word kind -> LAST; pseudo -> FIRST; unsupported -> IDLE.
  - FIRST, `out_ready` -> LAST with word1.
  - LAST, `out_ready`: new accept -> LAST/FIRST per kind; else IDLE.
- `in_ready = (state==IDLE) || (state==LAST && out_ready)`; never high in FIRST.
- `out_addr` increments by 1 on each output handshake; on transition from 2^ADDR_W-1 wraps to 0 and sets `wrap`.
- `start` outranks everything: next cycle state IDLE, `out_valid`=0, `out_addr`=0, `err`=`wrap`=0; a request presented with `start` is not accepted (`in_ready` forced 0 that cycle).

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=0, `err`=0, `wrap`=0, state IDLE; `in_ready`=1 after reset released.
- Latency: request accepted at edge N -> `out_valid` at N+1 (registered output).
- Throughput: one word/cycle with `out_ready` held high; pseudo-instruction costs two cycles.
- `out_instr`/`out_addr` stable while `out_valid && !out_ready` (except `start`/reset).
- Reset mid-pseudo: pending word1 discarded.

## Structure
- `minicpu_isa_pkg`: opcode and funct constants, `instr_kind_e` enum, `REG_AT`=1; shared with control unit and ALU decoder.
- Sub-module `instr_word_pack`: combinational kind/fields -> {word0, word1, is_pair, is_bad}; FSM, address counter, and output register in the top.

## Test plan
- ADD rd=3 rs=1 rt=2 after reset -> `out_instr`=0x00221820, `out_addr`=0 one cycle after accept.
- LW rt=8 rs=29 imm=0x0004 then JAL target=0x40, back-to-back -> 0x8FA80004 @0, 0x0C000040 @1, consecutive cycles.
- BLT rs=4 rt=5 imm=0xFFFD -> 0x0085082A @0, 0x1420FFFD @1; `in_ready` low during FIRST.
- `out_ready` low 3 cycles while holding a word -> `out_instr`, `out_addr` unchanged, `in_ready`=0, no words lost.
- `ADDR_W`=2, five NOPs -> addresses 0,1,2,3,0; `wrap`=1 after fifth handshake; `start` clears to 0.
- kind 5'h1F -> no `out_valid`, `err`=1; reset asserted after BLT word0 handshake -> `out_valid`=0, word1 never emitted.

Source files
------------

// File: rtl/minicpu_isa_pkg.sv
// MIPS subset ISA constants shared by the control unit, ALU decoder and the instruction encoder.
// Holds opcode/funct codes, the symbolic instruction kind enum and the field-packing helpers.
`timescale 1ns/1ps
package minicpu_isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // $at is reserved as the scratch register for pseudo-instruction expansion.
   localparam logic [4:0] REG_AT = 5'd1;

   typedef enum logic [4:0] {
      K_NOP   = 5'd0,
      K_ADD   = 5'd1,
      K_SUB   = 5'd2,
      K_AND   = 5'd3,
      K_OR    = 5'd4,
      K_SLT   = 5'd5,
      K_SLL   = 5'd6,
      K_JR    = 5'd7,
      K_LW    = 5'd8,
      K_SW    = 5'd9,
      K_BEQ   = 5'd10,
      K_BNE   = 5'd11,
      K_ADDI  = 5'd12,
      K_ADDIU = 5'd13,
      K_J     = 5'd14,
      K_JAL   = 5'd15,
      K_BLT   = 5'd16,
      K_BGE   = 5'd17
   } instr_kind_e;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational kind/fields -> instruction word(s); pseudo kinds yield a second word.
// Unknown kind codes flag is_bad and produce no meaningful word.
`timescale 1ns/1ps
module instr_word_pack
   import minicpu_isa_pkg::*;
(
   input  logic [4:0]  i_kind,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_shamt,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_target,
   output logic [31:0] o_word0,
   output logic [31:0] o_word1,
   output logic        o_is_pair,
   output logic        o_is_bad
);

   always_comb begin
      o_word0   = '0;
      o_word1   = '0;
      o_is_pair = 1'b0;
      o_is_bad  = 1'b0;
      case (i_kind)
         K_NOP:   o_word0 = '0;
         K_ADD:   o_word0 = r_word(i_rs, i_rt, i_rd, 5'd0, FN_ADD);
         K_SUB:   o_word0 = r_word(i_rs, i_rt, i_rd, 5'd0, FN_SUB);
         K_AND:   o_word0 = r_word(i_rs, i_rt, i_rd, 5'd0, FN_AND);
         K_OR:    o_word0 = r_word(i_rs, i_rt, i_rd, 5'd0, FN_OR);
         K_SLT:   o_word0 = r_word(i_rs, i_rt, i_rd, 5'd0, FN_SLT);
         K_SLL:   o_word0 = r_word(i_rs, i_rt, i_rd, i_shamt, FN_SLL);
         K_JR:    o_word0 = r_word(i_rs, 5'd0, 5'd0, 5'd0, FN_JR);
         K_LW:    o_word0 = i_word(OP_LW, i_rs, i_rt, i_imm);
         K_SW:    o_word0 = i_word(OP_SW, i_rs, i_rt, i_imm);
         K_BEQ:   o_word0 = i_word(OP_BEQ, i_rs, i_rt, i_imm);
         K_BNE:   o_word0 = i_word(OP_BNE, i_rs, i_rt, i_imm);
         K_ADDI:  o_word0 = i_word(OP_ADDI, i_rs, i_rt, i_imm);
         K_ADDIU: o_word0 = i_word(OP_ADDIU, i_rs, i_rt, i_imm);
         K_J:     o_word0 = {OP_J, i_target};
         K_JAL:   o_word0 = {OP_JAL, i_target};
         K_BLT, K_BGE: begin
            // slt $at,rs,rt then branch on $at: BLT taken when $at!=0, BGE when $at==0.
            o_word0   = r_word(i_rs, i_rt, REG_AT, 5'd0, FN_SLT);
            o_word1   = i_word((i_kind == K_BLT) ? OP_BNE : OP_BEQ, REG_AT, 5'd0, i_imm);
            o_is_pair = 1'b1;
         end
         default: o_is_bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_word_encoder.sv
// Streaming encoder: symbolic request -> 32-bit words with sequential addresses.
// Latency 1 cycle; in_ready drops while a held word is stalled or a pseudo's first word is pending.
`timescale 1ns/1ps
module instr_word_encoder
   import minicpu_isa_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic              wrap
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LAST = 2'd1, S_FIRST = 2'd2} state_e;

   state_e              r_state;
   logic                r_out_valid;
   logic [31:0]         r_out_instr;
   logic [31:0]         r_word1;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_err;
   logic                r_wrap;

   logic [31:0]         w_word0;
   logic [31:0]         w_word1;
   logic                w_is_pair;
   logic                w_is_bad;
   logic                w_accept;
   logic                w_out_hs;

   instr_word_pack u_pack (
      .i_kind    (in_kind),
      .i_rs      (in_rs),
      .i_rt      (in_rt),
      .i_rd      (in_rd),
      .i_shamt   (in_shamt),
      .i_imm     (in_imm),
      .i_target  (in_target),
      .o_word0   (w_word0),
      .o_word1   (w_word1),
      .o_is_pair (w_is_pair),
      .o_is_bad  (w_is_bad)
   );

   assign in_ready = !start && ((r_state == S_IDLE) || (r_state == S_LAST && out_ready));
   assign w_accept = in_valid && in_ready;
   assign w_out_hs = r_out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_word1     <= '0;
         r_addr      <= '0;
         r_err       <= 1'b0;
         r_wrap      <= 1'b0;
      end else if (start) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_addr      <= '0;
         r_err       <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         if (w_out_hs) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_addr == '1) r_wrap <= 1'b1;
         end
         case (r_state)
            S_FIRST: begin
               if (out_ready) begin
                  r_out_instr <= r_word1;
                  r_state     <= S_LAST;
               end
            end
            default: begin
               // Output slot is free when idle or when the held word leaves this cycle.
               if (r_state == S_IDLE || out_ready) begin
                  if (w_accept && !w_is_bad) begin
                     r_out_instr <= w_word0;
                     r_word1     <= w_word1;
                     r_out_valid <= 1'b1;
                     r_state     <= w_is_pair ? S_FIRST : S_LAST;
                  end else begin
                     if (w_accept) r_err <= 1'b1;
                     r_out_valid <= 1'b0;
                     r_state     <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_addr  = r_addr;
   assign err       = r_err;
   assign wrap      = r_wrap;

endmodule
